// File: rtl/fault_inject_ctrl.sv
// fault_inject_ctrl
// Runs a fault-injection campaign. For each injection it waits a fixed number
// of cycles, then uses an LFSR to pick a target register and a bit. It reads
// the register, flips that bit and hands the corrupted word over for
// write-back. It then watches the error flag of the fault-tolerance logic for
// a bounded window, and counts whether the fault was detected or missed.
//
// Parameters
//   LFSR_SEED    initial LFSR value (0 is replaced by 1)
//   OBS_TIMEOUT  observation window length in cycles (1..65535)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   enable_i       start in IDLE / abort when low
//   cfg_delay_i    idle cycles before each injection (latched at start)
//   cfg_count_i    injections per campaign (latched at start)
//   tgt_sel_o      target register index (0-3 core_0 x1..x4, 4-7 core_1 x1..x4)
//   tgt_rdata_i    current value of the selected register
//   inj_valid_o    corrupted value valid for write-back
//   inj_data_o     corrupted value
//   inj_ready_i    target accepted inj_data_o
//   error_i        detection flag (level)
//   busy_o         campaign in progress
//   done_o         campaign complete
//   inj_count_o    injections issued
//   det_count_o    injections detected
//   miss_count_o   injections not detected within the window
//   last_bit_o     bit index of the most recent injection
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable_i with a non-zero count
// WAIT    | delay timer counting down to the next injection
// SELECT  | LFSR advances once, target and bit chosen
// CAPTURE | selected register read, chosen bit inverted
// INJECT  | inj_valid_o held until inj_ready_i
// OBSERVE | observation window for error_i
// DONE    | campaign finished, counters held until enable_i drops

module fault_inject_ctrl #(
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int unsigned OBS_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [15:0] cfg_delay_i,
   input  logic [7:0]  cfg_count_i,
   output logic [2:0]  tgt_sel_o,
   input  logic [31:0] tgt_rdata_i,
   output logic        inj_valid_o,
   output logic [31:0] inj_data_o,
   input  logic        inj_ready_i,
   input  logic        error_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [7:0]  inj_count_o,
   output logic [7:0]  det_count_o,
   output logic [7:0]  miss_count_o,
   output logic [4:0]  last_bit_o
);

   localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] OBS_LAST = 16'(OBS_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SELECT,
      ST_CAPTURE,
      ST_INJECT,
      ST_OBSERVE,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] lfsr_next;
   logic [15:0] delay_q, delay_d;
   logic [7:0]  count_q, count_d;
   logic [15:0] dly_q, dly_d;
   logic [15:0] obs_q, obs_d;
   logic [2:0]  tgt_q, tgt_d;
   logic [4:0]  bit_q, bit_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  inj_q, inj_d;
   logic [7:0]  det_q, det_d;
   logic [7:0]  miss_q, miss_d;
   logic        obs_end;

   assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      delay_d = delay_q;
      count_d = count_q;
      dly_d   = dly_q;
      obs_d   = obs_q;
      tgt_d   = tgt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      inj_d   = inj_q;
      det_d   = det_q;
      miss_d  = miss_q;
      obs_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i && (cfg_count_i != 8'd0)) begin
               delay_d = cfg_delay_i;
               count_d = cfg_count_i;
               dly_d   = cfg_delay_i;
               inj_d   = 8'd0;
               det_d   = 8'd0;
               miss_d  = 8'd0;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (dly_q == 16'd0) begin
               state_d = ST_SELECT;
            end else begin
               dly_d = dly_q - 16'd1;
            end
         end

         // An abort here leaves the LFSR untouched, so an aborted campaign
         // does not consume a value it never injected.
         ST_SELECT: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else begin
               lfsr_d  = lfsr_next;
               tgt_d   = lfsr_next[2:0];
               bit_d   = lfsr_next[7:3];
               state_d = ST_CAPTURE;
            end
         end

         ST_CAPTURE: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else begin
               data_d  = tgt_rdata_i ^ (32'd1 << bit_q);
               state_d = ST_INJECT;
            end
         end

         // enable_i is not looked at until the handshake completes, so the
         // target never sees a valid that is withdrawn.
         ST_INJECT: begin
            if (inj_ready_i) begin
               inj_d = inj_q + 8'd1;
               if (!enable_i) begin
                  state_d = ST_IDLE;
               end else begin
                  obs_d   = OBS_LAST;
                  state_d = ST_OBSERVE;
               end
            end
         end

         // An abort takes priority over a detection in the same cycle.
         ST_OBSERVE: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (error_i) begin
               det_d   = det_q + 8'd1;
               obs_end = 1'b1;
            end else if (obs_q == 16'd0) begin
               miss_d  = miss_q + 8'd1;
               obs_end = 1'b1;
            end else begin
               obs_d = obs_q - 16'd1;
            end

            if (obs_end) begin
               if (inj_q == count_q) begin
                  state_d = ST_DONE;
               end else begin
                  dly_d   = delay_q;
                  state_d = ST_WAIT;
               end
            end
         end

         ST_DONE: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         lfsr_q  <= SEED;
         delay_q <= 16'd0;
         count_q <= 8'd0;
         dly_q   <= 16'd0;
         obs_q   <= 16'd0;
         tgt_q   <= 3'd0;
         bit_q   <= 5'd0;
         data_q  <= 32'd0;
         inj_q   <= 8'd0;
         det_q   <= 8'd0;
         miss_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         delay_q <= delay_d;
         count_q <= count_d;
         dly_q   <= dly_d;
         obs_q   <= obs_d;
         tgt_q   <= tgt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         inj_q   <= inj_d;
         det_q   <= det_d;
         miss_q  <= miss_d;
      end
   end

   assign tgt_sel_o    = tgt_q;
   assign last_bit_o   = bit_q;
   assign inj_data_o   = data_q;
   assign inj_valid_o  = (state_q == ST_INJECT);
   assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done_o       = (state_q == ST_DONE);
   assign inj_count_o  = inj_q;
   assign det_count_o  = det_q;
   assign miss_count_o = miss_q;

endmodule

// File: tb/tb_fault_inject_ctrl.sv
module tb_fault_inject_ctrl;

   localparam int          OBS  = 16;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] cfg_delay;
   logic [7:0]  cfg_count;
   logic [2:0]  tgt_sel;
   logic [31:0] tgt_rdata;
   logic        inj_valid;
   logic [31:0] inj_data;
   logic        inj_ready;
   logic        error;
   logic        busy;
   logic        done;
   logic [7:0]  inj_count;
   logic [7:0]  det_count;
   logic [7:0]  miss_count;
   logic [4:0]  last_bit;

   always #5 clk = ~clk;

   fault_inject_ctrl #(
      .LFSR_SEED   (SEED),
      .OBS_TIMEOUT (OBS)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .cfg_delay_i  (cfg_delay),
      .cfg_count_i  (cfg_count),
      .tgt_sel_o    (tgt_sel),
      .tgt_rdata_i  (tgt_rdata),
      .inj_valid_o  (inj_valid),
      .inj_data_o   (inj_data),
      .inj_ready_i  (inj_ready),
      .error_i      (error),
      .busy_o       (busy),
      .done_o       (done),
      .inj_count_o  (inj_count),
      .det_count_o  (det_count),
      .miss_count_o (miss_count),
      .last_bit_o   (last_bit)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] lfsr_m;
   logic [7:0]  exp_inj;
   logic [7:0]  exp_det;
   logic [7:0]  exp_miss;
   bit          rand_data;

   typedef struct {
      int delay;
      int count;
      int lat;
      int err_k;
      int err_w;
      int exp_det;
      int exp_miss;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [31:0] rnd_word();
      return rand_data ? 32'($urandom) : 32'h0;
   endfunction

   // error_i window: high on cycles k..k+w-1 counted from the handshake
   function automatic logic in_win(input int j, input int k, input int w);
      return (k >= 0) && (j >= k) && (j < k + w);
   endfunction

   task automatic wait_valid(input int k, input int w, inout int j, output int waited);
      waited = 0;
      forever begin
         @(negedge clk);
         if (inj_valid) break;
         waited++;
         j++;
         error     = in_win(j, k, w);
         tgt_rdata = rnd_word();
         if (waited > 400) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: inj_valid_o never rose within 400 cycles");
            break;
         end
      end
   endtask

   // Captured word is the tgt_rdata value present at the capture edge,
   // i.e. the value still being driven when inj_valid is first seen.
   task automatic check_inject(output logic [31:0] exp_data, output logic [2:0] exp_tgt);
      lfsr_m   = lfsr_adv(lfsr_m);
      exp_tgt  = lfsr_m[2:0];
      exp_data = tgt_rdata ^ (32'd1 << lfsr_m[7:3]);
      chk("tgt_sel", {29'd0, tgt_sel}, {29'd0, exp_tgt});
      chk("last_bit", {27'd0, last_bit}, {27'd0, lfsr_m[7:3]});
      chk("inj_data", inj_data, exp_data);
      chk("busy_inject", {31'd0, busy}, 32'd1);
   endtask

   task automatic campaign(input int d, input int n, input int lat_fix, input int k_fix,
                           input int w_fix, input bit rnd);
      int          j, k, w, lat, obs_len, waited, exp_wait;
      logic [31:0] exp_data;
      logic [2:0]  exp_tgt;
      bit          stable;
      enable    = 1'b1;
      cfg_delay = 16'(d);
      cfg_count = 8'(n);
      error     = 1'b0;
      inj_ready = 1'b0;
      tgt_rdata = rnd_word();
      exp_inj   = 8'd0;
      exp_det   = 8'd0;
      exp_miss  = 8'd0;
      k         = -1;
      w         = 0;
      j         = 0;
      obs_len   = 0;
      exp_wait  = d + 3;
      for (int i = 0; i < n; i++) begin
         wait_valid(k, w, j, waited);
         chk("wait_cycles", waited, exp_wait);
         check_inject(exp_data, exp_tgt);
         lat    = rnd ? int'($urandom_range(0, 4)) : lat_fix;
         stable = 1'b1;
         for (int l = 0; l < lat; l++) begin
            inj_ready = 1'b0;
            error     = 1'($urandom_range(0, 1));
            tgt_rdata = 32'($urandom);
            @(negedge clk);
            if (!inj_valid || inj_data !== exp_data || tgt_sel !== exp_tgt) stable = 1'b0;
         end
         chk("inject_hold", {31'd0, stable}, 32'd1);
         inj_ready = 1'b1;
         error     = 1'($urandom_range(0, 1));
         tgt_rdata = rnd_word();
         @(negedge clk);
         inj_ready = 1'b0;
         exp_inj++;
         chk("inj_count", {24'd0, inj_count}, {24'd0, exp_inj});
         chk("valid_after_hs", {31'd0, inj_valid}, 32'd0);
         if (rnd) begin
            k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
            w = int'($urandom_range(1, 3));
         end else begin
            k = k_fix;
            w = w_fix;
         end
         if (k >= 0 && k < OBS) begin
            exp_det++;
            obs_len = k + 1;
         end else begin
            exp_miss++;
            obs_len = OBS;
         end
         j         = 0;
         error     = in_win(0, k, w);
         tgt_rdata = rnd_word();
         exp_wait  = obs_len + d + 2;
      end
      waited = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         waited++;
         j++;
         error = in_win(j, k, w);
         if (waited > OBS + 5) break;
      end
      chk("last_observe_len", waited, obs_len - 1);
      chk("done", {31'd0, done}, 32'd1);
      chk("inj_final", {24'd0, inj_count}, {24'd0, exp_inj});
      chk("det_final", {24'd0, det_count}, {24'd0, exp_det});
      chk("miss_final", {24'd0, miss_count}, {24'd0, exp_miss});
      error = 1'b1;
      @(negedge clk);
      chk("done_hold", {31'd0, done}, 32'd1);
      chk("det_hold_in_done", {24'd0, det_count}, {24'd0, exp_det});
      error  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
      chk("inj_held_idle", {24'd0, inj_count}, {24'd0, exp_inj});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[6];
      int          j, waited;
      logic [31:0] exp_data;
      logic [2:0]  exp_tgt;
      bit          stable;

      vecs[0] = '{delay: 3, count: 1, lat: 0, err_k: 1,  err_w: 1, exp_det: 1, exp_miss: 0};
      vecs[1] = '{delay: 0, count: 3, lat: 0, err_k: -1, err_w: 0, exp_det: 0, exp_miss: 3};
      vecs[2] = '{delay: 5, count: 2, lat: 5, err_k: 15, err_w: 1, exp_det: 2, exp_miss: 0};
      vecs[3] = '{delay: 1, count: 2, lat: 2, err_k: 16, err_w: 2, exp_det: 0, exp_miss: 2};
      vecs[4] = '{delay: 2, count: 4, lat: 1, err_k: 0,  err_w: 3, exp_det: 4, exp_miss: 0};
      vecs[5] = '{delay: 7, count: 1, lat: 3, err_k: 8,  err_w: 1, exp_det: 1, exp_miss: 0};

      rst       = 1'b1;
      enable    = 1'b0;
      cfg_delay = 16'd0;
      cfg_count = 8'd0;
      tgt_rdata = 32'd0;
      inj_ready = 1'b0;
      error     = 1'b0;
      rand_data = 1'b0;
      lfsr_m    = SEED;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {tgt_sel, last_bit, inj_valid, busy, done}, 32'd0);
      chk("rst_data", inj_data, 32'd0);
      chk("rst_counts", {8'd0, inj_count, det_count, miss_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // First injection from the seed with a zero register: target 0, bit 14.
      campaign(3, 1, 0, 1, 1, 1'b0);
      chk("seed_tgt", {29'd0, tgt_sel}, 32'd0);
      chk("seed_bit", {27'd0, last_bit}, 32'd14);
      chk("seed_data", inj_data, 32'h0000_4000);
      chk("seed_det", {24'd0, det_count}, 32'd1);
      chk("seed_miss", {24'd0, miss_count}, 32'd0);

      rand_data = 1'b1;
      for (int v = 0; v < 6; v++) begin
         campaign(vecs[v].delay, vecs[v].count, vecs[v].lat, vecs[v].err_k, vecs[v].err_w, 1'b0);
         chk("tbl_det", {24'd0, det_count}, 32'(vecs[v].exp_det));
         chk("tbl_miss", {24'd0, miss_count}, 32'(vecs[v].exp_miss));
      end

      // cfg_count of zero does not start a campaign
      enable    = 1'b1;
      cfg_count = 8'd0;
      repeat (2) @(negedge clk);
      chk("count0_idle", {30'd0, busy, done}, 32'd0);
      enable = 1'b0;
      @(negedge clk);

      // Abort during WAIT: no LFSR step, no injection
      enable    = 1'b1;
      cfg_delay = 16'd10;
      cfg_count = 8'd2;
      repeat (4) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_wait_idle", {31'd0, busy}, 32'd0);
      chk("abort_wait_inj", {24'd0, inj_count}, 32'd0);

      // Abort during INJECT: deferred until the handshake, then straight to IDLE
      enable    = 1'b1;
      cfg_delay = 16'd1;
      cfg_count = 8'd3;
      j         = 0;
      wait_valid(-1, 0, j, waited);
      check_inject(exp_data, exp_tgt);
      enable = 1'b0;
      stable = 1'b1;
      for (int l = 0; l < 3; l++) begin
         tgt_rdata = 32'($urandom);
         @(negedge clk);
         if (!inj_valid || !busy || inj_data !== exp_data) stable = 1'b0;
      end
      chk("abort_inj_deferred", {31'd0, stable}, 32'd1);
      inj_ready = 1'b1;
      @(negedge clk);
      inj_ready = 1'b0;
      chk("abort_inj_idle", {29'd0, busy, done, inj_valid}, 32'd0);
      chk("abort_inj_counts", {8'd0, inj_count, det_count, miss_count}, 32'h0001_0000);
      error = 1'b1;
      repeat (2) @(negedge clk);
      error = 1'b0;
      chk("abort_inj_err_ignored", {24'd0, det_count}, 32'd0);

      // Abort during OBSERVE: neither detection nor miss is counted
      enable    = 1'b1;
      cfg_delay = 16'd0;
      cfg_count = 8'd3;
      j         = 0;
      wait_valid(-1, 0, j, waited);
      check_inject(exp_data, exp_tgt);
      inj_ready = 1'b1;
      @(negedge clk);
      inj_ready = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_obs_idle", {31'd0, busy}, 32'd0);
      chk("abort_obs_counts", {8'd0, inj_count, det_count, miss_count}, 32'h0001_0000);
      error = 1'b1;
      @(negedge clk);
      error = 1'b0;
      chk("abort_obs_err_ignored", {24'd0, det_count}, 32'd0);

      for (int r = 0; r < 6; r++) begin
         campaign(int'($urandom_range(0, 12)), int'($urandom_range(1, 5)), 0, 0, 0, 1'b1);
      end

      // Reset while in OBSERVE
      enable    = 1'b1;
      cfg_delay = 16'd2;
      cfg_count = 8'd2;
      j         = 0;
      wait_valid(-1, 0, j, waited);
      check_inject(exp_data, exp_tgt);
      inj_ready = 1'b1;
      @(negedge clk);
      inj_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      chk("rst_obs_outputs", {tgt_sel, last_bit, inj_valid, busy, done}, 32'd0);
      chk("rst_obs_data", inj_data, 32'd0);
      chk("rst_obs_counts", {8'd0, inj_count, det_count, miss_count}, 32'd0);
      rst    = 1'b0;
      lfsr_m = SEED;
      @(negedge clk);

      // Reset mid-handshake (INJECT, ready low)
      enable    = 1'b1;
      cfg_delay = 16'd0;
      cfg_count = 8'd1;
      j         = 0;
      wait_valid(-1, 0, j, waited);
      check_inject(exp_data, exp_tgt);
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      chk("rst_inj_outputs", {inj_valid, busy, done}, 32'd0);
      chk("rst_inj_data", inj_data, 32'd0);
      chk("rst_inj_count", {24'd0, inj_count}, 32'd0);
      rst    = 1'b0;
      lfsr_m = SEED;
      @(negedge clk);

      // LFSR restarts from the seed after reset
      rand_data = 1'b0;
      tgt_rdata = 32'd0;
      campaign(3, 1, 0, 1, 1, 1'b0);
      chk("reseed_tgt", {29'd0, tgt_sel}, 32'd0);
      chk("reseed_bit", {27'd0, last_bit}, 32'd14);
      chk("reseed_data", inj_data, 32'h0000_4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
